// File: rtl/univ_shift_reg_pkg.sv
// Shared definitions for the universal shift register: operation codes and burst FSM states.
package usr_pkg;

   localparam logic [2:0] MODE_HOLD = 3'd0;
   localparam logic [2:0] MODE_SHL  = 3'd1;
   localparam logic [2:0] MODE_SHR  = 3'd2;
   localparam logic [2:0] MODE_ROL  = 3'd3;
   localparam logic [2:0] MODE_ROR  = 3'd4;
   localparam logic [2:0] MODE_ASR  = 3'd5;
   localparam logic [2:0] MODE_INV  = 3'd6;
   localparam logic [2:0] MODE_CLR  = 3'd7;

   typedef enum logic [0:0] {
      StIdle = 1'b0,
      StRun  = 1'b1
   } usr_state_e;

endpackage

// File: rtl/univ_shift_reg_if.sv
// Control/data bundle of the universal shift register; clock and reset stay outside.
interface univ_shift_reg_if #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 4
);
   logic             En;
   logic             Load;
   logic [WIDTH-1:0] D;
   logic [2:0]       Mode;
   logic             SerInL;
   logic             SerInR;
   logic             Start;
   logic [CNT_W-1:0] Count;
   logic [WIDTH-1:0] Q;
   logic [WIDTH-1:0] notQ;
   logic             SerOutL;
   logic             SerOutR;
   logic             Busy;
   logic             Done;

   modport slave (
      input  En, Load, D, Mode, SerInL, SerInR, Start, Count,
      output Q, notQ, SerOutL, SerOutR, Busy, Done
   );

   modport master (
      output En, Load, D, Mode, SerInL, SerInR, Start, Count,
      input  Q, notQ, SerOutL, SerOutR, Busy, Done
   );
endinterface

// File: rtl/univ_shift_reg_bit_cell.sv
// One storage bit: 8:1 next-state mux over the neighbour taps, then a sync-reset flop.
module usr_bit_cell
   import usr_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_en,
   input  logic       i_load,
   input  logic       i_d,
   input  logic       i_step,
   input  logic [2:0] i_mode,
   input  logic       i_shl_in,
   input  logic       i_shr_in,
   input  logic       i_rol_in,
   input  logic       i_ror_in,
   input  logic       i_asr_in,
   output logic       o_q
);

   logic r_q;
   logic w_next;

   always_comb begin
      w_next = r_q;
      unique case (i_mode)
         MODE_HOLD: w_next = r_q;
         MODE_SHL:  w_next = i_shl_in;
         MODE_SHR:  w_next = i_shr_in;
         MODE_ROL:  w_next = i_rol_in;
         MODE_ROR:  w_next = i_ror_in;
         MODE_ASR:  w_next = i_asr_in;
         MODE_INV:  w_next = ~r_q;
         MODE_CLR:  w_next = 1'b0;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_q <= 1'b0;
      end else if (i_en) begin
         if (i_load) begin
            r_q <= i_d;
         end else if (i_step) begin
            r_q <= w_next;
         end
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: WIDTH bit cells plus a burst engine repeating one mode Count times.
module univ_shift_reg
   import usr_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 4
) (
   input  logic                    Clk,
   input  logic                    Reset,
   univ_shift_reg_if.slave         bus
);

   localparam logic [CNT_W-1:0] CntOne = 1;

   logic [WIDTH-1:0] w_q;
   usr_state_e       r_state, w_state_d;
   logic [CNT_W-1:0] r_cnt, w_cnt_d;
   logic [2:0]       r_mode, w_mode_d;
   logic             r_done, w_done_d;
   logic             w_step;
   logic [2:0]       w_op;

   // Priority below En: Load aborts a burst, a running burst uses its latched mode,
   // Start only arms the engine, otherwise the live Mode is applied once.
   always_comb begin
      w_state_d = r_state;
      w_cnt_d   = r_cnt;
      w_mode_d  = r_mode;
      w_done_d  = 1'b0;
      w_step    = 1'b0;
      w_op      = bus.Mode;
      if (bus.En) begin
         if (bus.Load) begin
            w_state_d = StIdle;
         end else if (r_state == StRun) begin
            w_step  = 1'b1;
            w_op    = r_mode;
            w_cnt_d = r_cnt - CntOne;
            if (r_cnt == CntOne) begin
               w_state_d = StIdle;
               w_done_d  = 1'b1;
            end
         end else if (bus.Start) begin
            if (bus.Count != '0) begin
               w_state_d = StRun;
               w_cnt_d   = bus.Count;
               w_mode_d  = bus.Mode;
            end else begin
               w_done_d = 1'b1;
            end
         end else begin
            w_step = 1'b1;
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state <= StIdle;
         r_cnt   <= '0;
         r_mode  <= MODE_HOLD;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_d;
         r_cnt   <= w_cnt_d;
         r_mode  <= w_mode_d;
         r_done  <= w_done_d;
      end
   end

   for (genvar gi = 0; gi < int'(WIDTH); gi++) begin : g_cell
      localparam int Lo = (gi == 0) ? int'(WIDTH) - 1 : gi - 1;
      localparam int Hi = (gi == int'(WIDTH) - 1) ? 0 : gi + 1;

      usr_bit_cell u_cell (
         .i_clk    (Clk),
         .i_reset  (Reset),
         .i_en     (bus.En),
         .i_load   (bus.Load),
         .i_d      (bus.D[gi]),
         .i_step   (w_step),
         .i_mode   (w_op),
         .i_shl_in ((gi == 0) ? bus.SerInL : w_q[Lo]),
         .i_shr_in ((gi == int'(WIDTH) - 1) ? bus.SerInR : w_q[Hi]),
         .i_rol_in (w_q[Lo]),
         .i_ror_in (w_q[Hi]),
         .i_asr_in ((gi == int'(WIDTH) - 1) ? w_q[gi] : w_q[Hi]),
         .o_q      (w_q[gi])
      );
   end

   assign bus.Q       = w_q;
   assign bus.notQ    = ~w_q;
   assign bus.SerOutL = w_q[WIDTH-1];
   assign bus.SerOutR = w_q[0];
   assign bus.Busy    = (r_state == StRun);
   assign bus.Done    = r_done;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg: cycle model feeds a scoreboard, plus fixed-value spot checks.
module tb_univ_shift_reg;

   logic Clk;
   logic Reset;
   int   checks = 0;
   int   errors = 0;
   int   busy_seen = 0;
   int   done_seen = 0;

   typedef struct {
      string      tag;
      logic [7:0] q;
      logic       busy;
      logic       done;
   } exp_t;

   exp_t sb[$];

   logic [7:0] m_q    = 8'h00;
   logic       m_busy = 1'b0;
   logic       m_done = 1'b0;
   logic [3:0] m_cnt  = 4'd0;
   logic [2:0] m_mode = 3'd0;

   univ_shift_reg_if #(.WIDTH(8), .CNT_W(4)) bus ();

   univ_shift_reg #(.WIDTH(8), .CNT_W(4)) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus.slave)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   function automatic logic [7:0] apply_op(input logic [2:0] m, input logic [7:0] q,
                                           input logic sl, input logic sr);
      case (m)
         3'd1:    return {q[6:0], sl};
         3'd2:    return {sr, q[7:1]};
         3'd3:    return {q[6:0], q[7]};
         3'd4:    return {q[0], q[7:1]};
         3'd5:    return {q[7], q[7:1]};
         3'd6:    return ~q;
         3'd7:    return 8'h00;
         default: return q;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // Advance the reference model by one edge from the currently driven inputs.
   task automatic model_step();
      if (Reset) begin
         m_q = 8'h00; m_busy = 1'b0; m_done = 1'b0; m_cnt = 4'd0; m_mode = 3'd0;
      end else if (!bus.En) begin
         m_done = 1'b0;
      end else begin
         m_done = 1'b0;
         if (bus.Load) begin
            m_q = bus.D;
            m_busy = 1'b0;
         end else if (m_busy) begin
            m_q = apply_op(m_mode, m_q, bus.SerInL, bus.SerInR);
            m_cnt = m_cnt - 4'd1;
            if (m_cnt == 4'd0) begin
               m_busy = 1'b0;
               m_done = 1'b1;
            end
         end else if (bus.Start) begin
            if (bus.Count != 4'd0) begin
               m_busy = 1'b1;
               m_cnt  = bus.Count;
               m_mode = bus.Mode;
            end else begin
               m_done = 1'b1;
            end
         end else begin
            m_q = apply_op(bus.Mode, m_q, bus.SerInL, bus.SerInR);
         end
      end
   endtask

   task automatic cycle(input string tag);
      exp_t e;
      model_step();
      sb.push_back('{tag: tag, q: m_q, busy: m_busy, done: m_done});
      @(posedge Clk);
      #1;
      e = sb.pop_front();
      chk({e.tag, ".q"}, bus.Q, e.q);
      chk({e.tag, ".notq"}, bus.notQ, ~e.q);
      chk({e.tag, ".serl"}, {7'd0, bus.SerOutL}, {7'd0, e.q[7]});
      chk({e.tag, ".serr"}, {7'd0, bus.SerOutR}, {7'd0, e.q[0]});
      chk({e.tag, ".busy"}, {7'd0, bus.Busy}, {7'd0, e.busy});
      chk({e.tag, ".done"}, {7'd0, bus.Done}, {7'd0, e.done});
      if (bus.Busy === 1'b1) busy_seen++;
      if (bus.Done === 1'b1) done_seen++;
   endtask

   initial begin
      Reset = 1'b1;
      bus.En = 1'b1; bus.Load = 1'b1; bus.D = 8'hFF; bus.Mode = 3'd0;
      bus.SerInL = 1'b0; bus.SerInR = 1'b0; bus.Start = 1'b0; bus.Count = 4'd0;
      cycle("reset");
      chk("reset_q", bus.Q, 8'h00);
      chk("reset_notq", bus.notQ, 8'hFF);
      chk("reset_busy_done", {6'd0, bus.Busy, bus.Done}, 8'h00);

      Reset = 1'b0; bus.D = 8'hA5;
      cycle("load_a5");
      bus.Load = 1'b0; bus.Mode = 3'd1; bus.SerInL = 1'b1;
      cycle("shl");
      chk("shl_q", bus.Q, 8'h4B);
      chk("shl_serl", {7'd0, bus.SerOutL}, 8'h00);

      // single steps through remaining modes
      bus.Mode = 3'd2; bus.SerInR = 1'b1; cycle("shr");
      bus.Mode = 3'd6; cycle("inv");
      bus.Mode = 3'd4; cycle("ror");
      bus.Mode = 3'd5; cycle("asr");
      bus.Mode = 3'd0; cycle("hold");
      bus.Mode = 3'd7; cycle("clr");
      chk("clr_q", bus.Q, 8'h00);

      // ROL burst of 3; Start held into the run must be ignored
      bus.Load = 1'b1; bus.D = 8'h81; cycle("load_81");
      bus.Load = 1'b0; bus.Mode = 3'd3; bus.Start = 1'b1; bus.Count = 4'd3;
      cycle("rol_start");
      chk("rol_start_q", bus.Q, 8'h81);
      bus.Count = 4'd0; bus.Mode = 3'd7;
      cycle("rol_s1");
      bus.Start = 1'b0;
      cycle("rol_s2");
      cycle("rol_s3");
      chk("rol_q", bus.Q, 8'h0C);
      chk("rol_done", {7'd0, bus.Done}, 8'h01);
      bus.Mode = 3'd0;
      cycle("rol_after");

      // ASR burst of 4 with a 2-cycle pause
      bus.Load = 1'b1; bus.D = 8'h80; cycle("load_80");
      busy_seen = 0; done_seen = 0;
      bus.Load = 1'b0; bus.Mode = 3'd5; bus.Start = 1'b1; bus.Count = 4'd4;
      cycle("asr_start");
      bus.Start = 1'b0; bus.Mode = 3'd1;
      cycle("asr_s1");
      cycle("asr_s2");
      bus.En = 1'b0;
      cycle("asr_p1");
      cycle("asr_p2");
      bus.En = 1'b1;
      cycle("asr_s3");
      cycle("asr_s4");
      chk("asr_q", bus.Q, 8'hF8);
      bus.Mode = 3'd0;
      cycle("asr_after");
      chk("asr_busy_cycles", 8'(busy_seen), 8'd6);
      chk("asr_done_pulses", 8'(done_seen), 8'd1);

      // Start with Count=0
      busy_seen = 0; done_seen = 0;
      bus.Mode = 3'd1; bus.Start = 1'b1; bus.Count = 4'd0;
      cycle("zero_start");
      chk("zero_done", {7'd0, bus.Done}, 8'h01);
      chk("zero_q", bus.Q, 8'hF8);
      bus.Start = 1'b0; bus.Mode = 3'd0;
      cycle("zero_after");
      chk("zero_busy_never", 8'(busy_seen), 8'd0);

      // Load aborts a burst
      busy_seen = 0; done_seen = 0;
      bus.Mode = 3'd4; bus.Start = 1'b1; bus.Count = 4'd5;
      cycle("abort_start");
      bus.Start = 1'b0;
      cycle("abort_s1");
      bus.Load = 1'b1; bus.D = 8'h3C;
      cycle("abort_load");
      chk("abort_q", bus.Q, 8'h3C);
      bus.Load = 1'b0; bus.Mode = 3'd0;
      cycle("abort_a1");
      cycle("abort_a2");
      chk("abort_no_done", 8'(done_seen), 8'd0);

      // Reset mid-burst
      done_seen = 0;
      bus.Mode = 3'd3; bus.Start = 1'b1; bus.Count = 4'd4;
      cycle("rst_start");
      bus.Start = 1'b0;
      cycle("rst_s1");
      Reset = 1'b1;
      cycle("rst_hit");
      chk("rst_q", bus.Q, 8'h00);
      Reset = 1'b0; bus.Mode = 3'd0;
      cycle("rst_a1");
      cycle("rst_a2");
      chk("rst_no_done", 8'(done_seen), 8'd0);

      // Rotate burst of WIDTH steps restores Q
      bus.Load = 1'b1; bus.D = 8'h5A; cycle("load_5a");
      bus.Load = 1'b0; bus.Mode = 3'd4; bus.Start = 1'b1; bus.Count = 4'd8;
      cycle("ror8_start");
      bus.Start = 1'b0; bus.Mode = 3'd0;
      for (int i = 0; i < 8; i++) cycle("ror8_step");
      chk("ror8_q", bus.Q, 8'h5A);
      chk("ror8_done", {7'd0, bus.Done}, 8'h01);
      cycle("ror8_after");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
